// File: rtl/control_event_dispatcher_pkg.sv
// Shared definitions for the control event dispatcher: default geometry and the
// states of the offer handshake.
package control_event_dispatcher_pkg;

  localparam int CED_WIDTH    = 16;
  localparam int CED_ID_WIDTH = 4;

  typedef enum logic {
    CED_IDLE  = 1'b0,
    CED_OFFER = 1'b1
  } ced_state_e;

endpackage

// File: rtl/control_event_dispatcher_arbiter.sv
// Combinational round-robin picker: returns the first requesting index found
// when scanning upward (with wrap) from start_i.
module ctrl_rr_arbiter #(
  parameter int WIDTH    = 16,
  parameter int ID_WIDTH = 4
) (
  input  logic [WIDTH-1:0]    req_i,
  input  logic [ID_WIDTH-1:0] start_i,
  output logic [ID_WIDTH-1:0] grant_o,
  output logic                any_o
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = (int'(start_i) + k) % WIDTH;
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/control_event_dispatcher.sv
// Watches the registered control word, turns each per-bit transition into one
// event (id + level) offered over a valid/ack handshake, and flags overruns.
module control_event_dispatcher
  import control_event_dispatcher_pkg::*;
#(
  parameter int WIDTH    = CED_WIDTH,
  parameter int ID_WIDTH = CED_ID_WIDTH
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    iControlRegister,
  output logic                oEventValid,
  output logic [ID_WIDTH-1:0] oEventId,
  output logic                oEventLevel,
  input  logic                iEventAck,
  output logic [WIDTH-1:0]    oPending,
  output logic                oOverrun,
  input  logic                iClearOverrun
);

  ced_state_e          state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [WIDTH-1:0]    pending_q, pending_d;
  logic [ID_WIDTH-1:0] event_id_q, event_id_d;
  logic                event_level_q, event_level_d;
  logic                event_valid_q, event_valid_d;
  logic                overrun_q, overrun_d;
  // Next index the round-robin scan starts from; 0 after reset so bit 0 goes first.
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [WIDTH-1:0]    change;
  logic                accept;
  logic                overrun_set;
  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_any;

  assign change = iControlRegister ^ prev_q;
  assign accept = event_valid_q & iEventAck;

  ctrl_rr_arbiter #(
    .WIDTH   (WIDTH),
    .ID_WIDTH(ID_WIDTH)
  ) u_arbiter (
    .req_i  (pending_q),
    .start_i(rr_ptr_q),
    .grant_o(grant_id),
    .any_o  (grant_any)
  );

  always_comb begin
    state_d       = state_q;
    prev_d        = iControlRegister;
    pending_d     = pending_q;
    event_id_d    = event_id_q;
    event_level_d = event_level_q;
    event_valid_d = event_valid_q;
    rr_ptr_d      = rr_ptr_q;
    overrun_set   = 1'b0;

    for (int i = 0; i < WIDTH; i++) begin
      if (accept && (event_id_q == ID_WIDTH'(i))) begin
        // Level moved after the offer was latched: re-dispatch the final level.
        pending_d[i] = change[i] | (prev_q[i] != event_level_q);
        if (prev_q[i] != event_level_q) overrun_set = 1'b1;
      end else if (change[i] && pending_q[i]) begin
        overrun_set = 1'b1;
      end else begin
        pending_d[i] = pending_q[i] | change[i];
      end
    end

    if (overrun_set)        overrun_d = 1'b1;
    else if (iClearOverrun) overrun_d = 1'b0;
    else                    overrun_d = overrun_q;

    unique case (state_q)
      CED_IDLE: begin
        if (grant_any) begin
          event_id_d    = grant_id;
          event_level_d = prev_q[grant_id];
          event_valid_d = 1'b1;
          rr_ptr_d      = ID_WIDTH'((int'(grant_id) + 1) % WIDTH);
          state_d       = CED_OFFER;
        end
      end
      CED_OFFER: begin
        if (iEventAck) begin
          event_valid_d = 1'b0;
          state_d       = CED_IDLE;
        end
      end
      default: state_d = CED_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= CED_IDLE;
      prev_q        <= '0;
      pending_q     <= '0;
      event_id_q    <= '0;
      event_level_q <= 1'b0;
      event_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      pending_q     <= pending_d;
      event_id_q    <= event_id_d;
      event_level_q <= event_level_d;
      event_valid_q <= event_valid_d;
      overrun_q     <= overrun_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign oEventValid = event_valid_q;
  assign oEventId    = event_id_q;
  assign oEventLevel = event_level_q;
  assign oPending    = pending_q;
  assign oOverrun    = overrun_q;

endmodule

// File: tb/tb_control_event_dispatcher.sv
// Self-checking bench for control_event_dispatcher: expected events are queued
// as stimulus is driven and compared on every valid/ack transfer.
module tb_control_event_dispatcher;

  localparam int W  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  ctrl;
  logic          ev_valid;
  logic [IW-1:0] ev_id;
  logic          ev_level;
  logic          ack;
  logic [W-1:0]  pending;
  logic          overrun;
  logic          clr;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          lvl;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  control_event_dispatcher #(.WIDTH(W), .ID_WIDTH(IW)) dut (
    .Clock           (clk),
    .Reset           (rst),
    .iControlRegister(ctrl),
    .oEventValid     (ev_valid),
    .oEventId        (ev_id),
    .oEventLevel     (ev_level),
    .iEventAck       (ack),
    .oPending        (pending),
    .oOverrun        (overrun),
    .iClearOverrun   (clr)
  );

  always #5 clk = ~clk;

  // Scoreboard: every transfer must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && ev_valid && ack) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got id=%0d lvl=%0b, expected no event", ev_id, ev_level);
      end else begin
        e = sb.pop_front();
        if ({ev_id, ev_level} !== e) begin
          n_err++;
          $display("FAIL sb_event: got id=%0d lvl=%0b, expected id=%0d lvl=%0b",
                   ev_id, ev_level, e.id, e.lvl);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input logic lvl);
    ev_t e;
    e.id  = IW'(id);
    e.lvl = lvl;
    sb.push_back(e);
  endtask

  task automatic apply_reset(input logic [W-1:0] v);
    rst  = 1'b1;
    ctrl = v;
    ack  = 1'b0;
    clr  = 1'b0;
    step(2);
    rst = 1'b0;
    sb.delete();
  endtask

  // Wait (bounded) for an offer, then accept it for one cycle.
  task automatic ack_next(input int budget);
    int waited = 0;
    while (!ev_valid && waited < budget) begin
      step();
      waited++;
    end
    n_cmp++;
    if (!ev_valid) begin
      n_err++;
      $display("FAIL ack_timeout: valid=%0b after %0d cycles, expected 1", ev_valid, budget);
    end else begin
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ctrl = 16'h0005;
    ack  = 1'b0;
    clr  = 1'b0;
    step(3);
    n_cmp++;
    if ({ev_valid, pending, overrun} !== {1'b0, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: valid=%0b pending=%h overrun=%0b, expected 0/0000/0",
               ev_valid, pending, overrun);
    end
    rst = 1'b0;
    push(0, 1'b1);
    push(2, 1'b1);
    step();
    n_cmp++;
    if (pending !== 16'h0005) begin
      n_err++;
      $display("FAIL reset_pending: pending=%h, expected 0005", pending);
    end
    ack_next(4);
    ack_next(4);
    step(3);
    n_cmp++;
    if ({ev_valid, pending, overrun} !== {1'b0, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_idle: valid=%0b pending=%h overrun=%0b, expected 0/0000/0",
               ev_valid, pending, overrun);
    end
  endtask

  task automatic test_latency();
    apply_reset('0);
    step(2);
    ctrl[7] = 1'b1;
    push(7, 1'b1);
    step();
    n_cmp++;
    if ({pending, ev_valid} !== {16'h0080, 1'b0}) begin
      n_err++;
      $display("FAIL lat_pending: pending=%h valid=%0b, expected 0080/0", pending, ev_valid);
    end
    step();
    n_cmp++;
    if ({ev_valid, ev_id, ev_level} !== {1'b1, 4'd7, 1'b1}) begin
      n_err++;
      $display("FAIL lat_offer: valid=%0b id=%0d lvl=%0b, expected 1/7/1", ev_valid, ev_id, ev_level);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++;
    if ({pending, overrun} !== {16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL lat_clear: pending=%h overrun=%0b, expected 0000/0", pending, overrun);
    end
  endtask

  task automatic test_overrun_coalesce();
    apply_reset('0);
    step(2);
    ctrl[3] = 1'b1;
    push(3, 1'b1);
    step();
    ctrl[3] = 1'b0;
    push(3, 1'b0);
    step();
    n_cmp++;
    if ({overrun, ev_valid, ev_id, ev_level} !== {1'b1, 1'b1, 4'd3, 1'b1}) begin
      n_err++;
      $display("FAIL ovr_first: ovr=%0b valid=%0b id=%0d lvl=%0b, expected 1/1/3/1",
               overrun, ev_valid, ev_id, ev_level);
    end
    step(3);
    n_cmp++;
    if ({ev_valid, ev_id, ev_level} !== {1'b1, 4'd3, 1'b1}) begin
      n_err++;
      $display("FAIL ovr_hold: valid=%0b id=%0d lvl=%0b, expected 1/3/1", ev_valid, ev_id, ev_level);
    end
    ack_next(1);
    ack_next(4);
    step(3);
    n_cmp++;
    if ({ev_valid, pending, overrun} !== {1'b0, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL ovr_end: valid=%0b pending=%h ovr=%0b, expected 0/0000/1",
               ev_valid, pending, overrun);
    end
  endtask

  task automatic test_round_robin();
    apply_reset('0);
    step(2);
    ctrl = 16'h0010;
    push(4, 1'b1);
    ack_next(4);
    step(2);
    // Bits 1 and 9 rise while bit 4 falls; the scan resumes after id 4.
    ctrl = 16'h0202;
    push(9, 1'b1);
    push(1, 1'b1);
    push(4, 1'b0);
    step(2);
    n_cmp++;
    if ({ev_valid, ev_id, ev_level} !== {1'b1, 4'd9, 1'b1}) begin
      n_err++;
      $display("FAIL rr_first: valid=%0b id=%0d lvl=%0b, expected 1/9/1", ev_valid, ev_id, ev_level);
    end
    step(3);
    n_cmp++;
    if ({ev_valid, ev_id, ev_level} !== {1'b1, 4'd9, 1'b1}) begin
      n_err++;
      $display("FAIL rr_stable: valid=%0b id=%0d lvl=%0b, expected 1/9/1", ev_valid, ev_id, ev_level);
    end
    ack_next(4);
    ack_next(4);
    ack_next(4);
    step(2);
    n_cmp++;
    if ({ev_valid, pending, overrun} !== {1'b0, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL rr_end: valid=%0b pending=%h ovr=%0b, expected 0/0000/0",
               ev_valid, pending, overrun);
    end
  endtask

  task automatic test_reset_mid_offer();
    apply_reset('0);
    step(2);
    ctrl = 16'h0100;
    step(2);
    ctrl = 16'h0000;
    step();
    n_cmp++;
    if ({ev_valid, overrun} !== {1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL mid_pre: valid=%0b ovr=%0b, expected 1/1", ev_valid, overrun);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({ev_valid, pending, overrun, ev_id, ev_level} !== {1'b0, 16'h0000, 1'b0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: valid=%0b pending=%h ovr=%0b id=%0d lvl=%0b, expected all 0",
               ev_valid, pending, overrun, ev_id, ev_level);
    end
    rst = 1'b0;
    step(3);
    n_cmp++;
    if (ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_after: valid=%0b, expected 0", ev_valid);
    end
  endtask

  task automatic test_clear_priority();
    apply_reset('0);
    step(2);
    ctrl[5] = 1'b1;
    push(5, 1'b1);
    step();
    ctrl[5] = 1'b0;
    push(5, 1'b0);
    clr = 1'b1;
    step();
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL clr_same: ovr=%0b, expected 1", overrun);
    end
    step();
    clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL clr_alone: ovr=%0b, expected 0", overrun);
    end
    ack_next(4);
    ack_next(4);
    step(2);
    n_cmp++;
    if ({ev_valid, pending} !== {1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL clr_end: valid=%0b pending=%h, expected 0/0000", ev_valid, pending);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overrun_coalesce();
    test_round_robin();
    test_reset_mid_offer();
    test_clear_priority();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d events never seen, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
